// File: rtl/axi4slave_sram.sv
// axi4slave_sram: AXI4 slave that executes read/write bursts one 32-bit word
// per beat on a single-port SRAM-style memory. One transaction at a time,
// INCR bursts up to 256 beats, round-robin tie-break between AR and AW.
// Optional feature macro: AXI4SLAVE_ADDR_CHECK_EN. When it is defined,
// transactions whose start address falls outside [ADDR_BASE, ADDR_BASE+ADDR_SIZE)
// are answered with DECERR and never touch the memory.
module axi4slave_sram #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter logic [31:0] ADDR_SIZE = 32'h0001_0000
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    // write address channel
    input  logic        AWID,
    input  logic [31:0] AWADDR,
    input  logic [7:0]  AWLEN,
    input  logic [2:0]  AWSIZE,
    input  logic [1:0]  AWBURST,
    input  logic        AWLOCK,
    input  logic [3:0]  AWCACHE,
    input  logic [2:0]  AWPROT,
    input  logic [3:0]  AWQOS,
    input  logic [3:0]  AWREGION,
    input  logic        AWUSER,
    input  logic        AWVALID,
    output logic        AWREADY,
    // write data channel
    input  logic        WID,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    input  logic        WLAST,
    input  logic        WUSER,
    input  logic        WVALID,
    output logic        WREADY,
    // write response channel
    output logic        BID,
    output logic [1:0]  BRESP,
    output logic        BUSER,
    output logic        BVALID,
    input  logic        BREADY,
    // read address channel
    input  logic        ARID,
    input  logic [31:0] ARADDR,
    input  logic [7:0]  ARLEN,
    input  logic [2:0]  ARSIZE,
    input  logic [1:0]  ARBURST,
    input  logic        ARLOCK,
    input  logic [3:0]  ARCACHE,
    input  logic [2:0]  ARPROT,
    input  logic [3:0]  ARQOS,
    input  logic [3:0]  ARREGION,
    input  logic        ARUSER,
    input  logic        ARVALID,
    output logic        ARREADY,
    // read data channel
    output logic        RID,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RLAST,
    output logic        RUSER,
    output logic        RVALID,
    input  logic        RREADY,
    // SRAM side
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_c_en,
    output logic        mem_w_en,
    output logic [3:0]  mem_b_en,
    input  logic        mem_error,
    input  logic        mem_stall
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_DATA = 3'd1,
        WR_MEM  = 3'd2,
        WR_RESP = 3'd3,
        RD_MEM  = 3'd4,
        RD_WAIT = 3'd5,
        RD_DATA = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        id_q, id_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        err_q, err_d;        // sticky SRAM error over a write burst
    logic        decerr_q, decerr_d;  // current transaction is outside the window
    logic        last_rd_q, last_rd_d; // last grant went to the read channel
    logic        arready_q, arready_d;
    logic        awready_q, awready_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

`ifdef AXI4SLAVE_ADDR_CHECK_EN
    // Window test written as an offset compare so BASE+SIZE may reach 2^32.
    function automatic logic addr_hit(input logic [31:0] a);
        addr_hit = (a >= ADDR_BASE) && ((a - ADDR_BASE) < ADDR_SIZE);
    endfunction
`endif

    // Sideband inputs and the byte-offset address bits carry no meaning here.
    logic unused_sideband_s;
    assign unused_sideband_s = ^{AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS,
                                 AWREGION, AWUSER, ARSIZE, ARBURST, ARLOCK, ARCACHE,
                                 ARPROT, ARQOS, ARREGION, ARUSER, WID, WLAST, WUSER,
                                 AWADDR[1:0], ARADDR[1:0]
`ifndef AXI4SLAVE_ADDR_CHECK_EN
                                 , ADDR_BASE, ADDR_SIZE
`endif
                                 };

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            addr_q    <= 32'h0000_0000;
            cnt_q     <= 8'd0;
            id_q      <= 1'b0;
            wdata_q   <= 32'h0000_0000;
            wstrb_q   <= 4'h0;
            err_q     <= 1'b0;
            decerr_q  <= 1'b0;
            last_rd_q <= 1'b0;
            arready_q <= 1'b0;
            awready_q <= 1'b0;
            rdata_q   <= 32'h0000_0000;
            rresp_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            err_q     <= err_d;
            decerr_q  <= decerr_d;
            last_rd_q <= last_rd_d;
            arready_q <= arready_d;
            awready_q <= awready_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Next-state logic, datapath updates and registered AR/AW ready arbitration.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        err_d     = err_q;
        decerr_d  = decerr_q;
        last_rd_d = last_rd_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        arready_d = 1'b0;
        awready_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (arready_q && ARVALID) begin
                    id_d      = ARID;
                    addr_d    = {ARADDR[31:2], 2'b00};
                    cnt_d     = ARLEN;
                    last_rd_d = 1'b1;
`ifdef AXI4SLAVE_ADDR_CHECK_EN
                    decerr_d  = ~addr_hit(ARADDR);
`else
                    decerr_d  = 1'b0;
`endif
                    state_d   = RD_MEM;
                end else if (awready_q && AWVALID) begin
                    id_d      = AWID;
                    addr_d    = {AWADDR[31:2], 2'b00};
                    cnt_d     = AWLEN;
                    last_rd_d = 1'b0;
                    err_d     = 1'b0;
`ifdef AXI4SLAVE_ADDR_CHECK_EN
                    decerr_d  = ~addr_hit(AWADDR);
`else
                    decerr_d  = 1'b0;
`endif
                    state_d   = WR_DATA;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_DATA: begin
                if (WVALID) begin
                    wdata_d = WDATA;
                    wstrb_d = WSTRB;
                    state_d = WR_MEM;
                end else begin
                    state_d = WR_DATA;
                end
            end
            WR_MEM: begin
                // A decoded-out beat makes no access, so a stall cannot hold it.
                if (mem_stall && !decerr_q) begin
                    state_d = WR_MEM;
                end else begin
                    err_d = err_q | (mem_error & ~decerr_q);
                    if (cnt_q == 8'd0) begin
                        state_d = WR_RESP;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        addr_d  = addr_q + 32'd4;
                        state_d = WR_DATA;
                    end
                end
            end
            WR_RESP: begin
                if (BREADY) begin
                    err_d    = 1'b0;
                    decerr_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    state_d = WR_RESP;
                end
            end
            RD_MEM: begin
                if (mem_stall && !decerr_q) begin
                    state_d = RD_MEM;
                end else begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (decerr_q) begin
                    rdata_d = 32'h0000_0000;
                    rresp_d = 2'b11;
                end else begin
                    rdata_d = mem_rdata;
                    rresp_d = mem_error ? 2'b10 : 2'b00;
                end
                state_d = RD_DATA;
            end
            RD_DATA: begin
                if (RREADY) begin
                    if (cnt_q == 8'd0) begin
                        decerr_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        addr_d  = addr_q + 32'd4;
                        state_d = RD_MEM;
                    end
                end else begin
                    state_d = RD_DATA;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Ready is registered: decided one cycle ahead from the valids seen now.
        if (state_d == IDLE) begin
            if (ARVALID && AWVALID) begin
                arready_d = ~last_rd_d;
                awready_d = last_rd_d;
            end else if (ARVALID) begin
                arready_d = 1'b1;
            end else if (AWVALID) begin
                awready_d = 1'b1;
            end else begin
                arready_d = 1'b0;
                awready_d = 1'b0;
            end
        end else begin
            arready_d = 1'b0;
            awready_d = 1'b0;
        end
    end

    assign ARREADY   = arready_q;
    assign AWREADY   = awready_q;
    assign WREADY    = (state_q == WR_DATA);
    assign BVALID    = (state_q == WR_RESP);
    assign BID       = id_q;
    assign BRESP     = !BVALID ? 2'b00 : (decerr_q ? 2'b11 : (err_q ? 2'b10 : 2'b00));
    assign BUSER     = 1'b0;
    assign RVALID    = (state_q == RD_DATA);
    assign RID       = id_q;
    assign RDATA     = rdata_q;
    assign RRESP     = rresp_q;
    assign RLAST     = RVALID && (cnt_q == 8'd0);
    assign RUSER     = 1'b0;

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_c_en  = ((state_q == WR_MEM) || (state_q == RD_MEM)) && !decerr_q;
    assign mem_w_en  = (state_q == WR_MEM) && !decerr_q;
    assign mem_b_en  = (state_q == WR_MEM) ? wstrb_q : 4'hF;

endmodule

// File: tb/tb_axi4slave_sram.sv
// tb_axi4slave_sram: directed bench for axi4slave_sram. A table of single-beat
// reads is applied in a loop; bursts, stalls, errors, arbitration and reset
// abort are hand-written sequences. Timing is sampled 1 time unit after the
// rising edge; "cycle N+k" means k edges after the handshake edge N.
module tb_axi4slave_sram;

    logic        ACLK;
    logic        ARESETn;
    logic        AWID, AWVALID, AWREADY;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic        WID, WLAST, WUSER, WVALID, WREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        BID, BUSER, BVALID, BREADY;
    logic [1:0]  BRESP;
    logic        ARID, ARVALID, ARREADY;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic        RID, RLAST, RUSER, RVALID, RREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_c_en, mem_w_en, mem_error, mem_stall;
    logic [3:0]  mem_b_en;

    logic [31:0] sram [0:1023];
    int          cen_cnt = 0;
    int          checks = 0;
    int          failures = 0;

    axi4slave_sram #(.ADDR_BASE(32'h0000_0000), .ADDR_SIZE(32'h0000_1000)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(3'd2), .AWBURST(2'b01),
        .AWLOCK(1'b0), .AWCACHE(4'h0), .AWPROT(3'd0), .AWQOS(4'h0), .AWREGION(4'h0),
        .AWUSER(1'b0), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WUSER(WUSER),
        .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BUSER(BUSER), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(3'd2), .ARBURST(2'b01),
        .ARLOCK(1'b0), .ARCACHE(4'h0), .ARPROT(3'd0), .ARQOS(4'h0), .ARREGION(4'h0),
        .ARUSER(1'b0), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RUSER(RUSER),
        .RVALID(RVALID), .RREADY(RREADY),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_c_en(mem_c_en), .mem_w_en(mem_w_en), .mem_b_en(mem_b_en),
        .mem_error(mem_error), .mem_stall(mem_stall)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // SRAM model: read data appears the cycle after an accepted read.
    always @(posedge ACLK) begin
        if (mem_c_en) cen_cnt <= cen_cnt + 1;
        if (mem_c_en && !mem_w_en && !mem_stall) mem_rdata <= sram[mem_addr[11:2]];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: timeout waiting for DUT", nm);
    endtask

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    // Issue AR and return in cycle N+1 after the handshake edge.
    task automatic send_ar(input logic id, input logic [31:0] addr, input logic [7:0] len);
        int n;
        ARID = id; ARADDR = addr; ARLEN = len; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 16) begin tick(); n++; end
        if (n == 16) timeout("ar_handshake");
        tick();
        ARVALID = 1'b0;
    endtask

    task automatic send_aw(input logic id, input logic [31:0] addr, input logic [7:0] len);
        int n;
        AWID = id; AWADDR = addr; AWLEN = len; AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 16) begin tick(); n++; end
        if (n == 16) timeout("aw_handshake");
        tick();
        AWVALID = 1'b0;
    endtask

    // Single-beat read with exact cycle checks.
    task automatic do_read1(input logic id, input logic [31:0] addr, input logic err,
                            input logic [31:0] exp_maddr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp);
        send_ar(id, addr, 8'd0);
        check("rd_cen_n1", {31'd0, mem_c_en}, 32'd1);
        check("rd_wen_n1", {31'd0, mem_w_en}, 32'd0);
        check("rd_addr_n1", mem_addr, exp_maddr);
        check("rd_ben_n1", {28'd0, mem_b_en}, 32'h0000_000F);
        tick();
        mem_error = err;
        check("rd_rvalid_n2", {31'd0, RVALID}, 32'd0);
        tick();
        mem_error = 1'b0;
        check("rd_rvalid_n3", {31'd0, RVALID}, 32'd1);
        check("rd_rdata", RDATA, exp_data);
        check("rd_rresp", {30'd0, RRESP}, {30'd0, exp_resp});
        check("rd_rlast", {31'd0, RLAST}, 32'd1);
        check("rd_rid", {31'd0, RID}, {31'd0, id});
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        check("rd_rvalid_done", {31'd0, RVALID}, 32'd0);
    endtask

    // Write burst, 2 cycles per beat, then a response held one cycle by BREADY=0.
    task automatic do_write(input logic id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [3:0] strb, input logic [31:0] d0, input int err_beat,
                            input logic [1:0] exp_bresp);
        logic [31:0] exp_a, wd;
        exp_a = {addr[31:2], 2'b00};
        wd = d0;
        send_aw(id, addr, len);
        for (int b = 0; b <= int'(len); b++) begin
            check("wr_wready", {31'd0, WREADY}, 32'd1);
            WDATA = wd; WSTRB = strb; WVALID = 1'b1;
            tick();
            WVALID = 1'b0;
            mem_error = (b == err_beat);
            check("wr_cen", {31'd0, mem_c_en}, 32'd1);
            check("wr_wen", {31'd0, mem_w_en}, 32'd1);
            check("wr_addr", mem_addr, exp_a);
            check("wr_ben", {28'd0, mem_b_en}, {28'd0, strb});
            check("wr_wdata", mem_wdata, wd);
            check("wr_bvalid_early", {31'd0, BVALID}, 32'd0);
            tick();
            mem_error = 1'b0;
            exp_a = exp_a + 32'd4;
            wd = wd + 32'd1;
        end
        check("wr_bvalid", {31'd0, BVALID}, 32'd1);
        check("wr_bresp", {30'd0, BRESP}, {30'd0, exp_bresp});
        check("wr_bid", {31'd0, BID}, {31'd0, id});
        tick();
        check("wr_bvalid_hold", {31'd0, BVALID}, 32'd1);
        check("wr_bresp_hold", {30'd0, BRESP}, {30'd0, exp_bresp});
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        check("wr_bvalid_done", {31'd0, BVALID}, 32'd0);
    endtask

    typedef struct {
        logic        id;
        logic [31:0] addr;
        logic        err;
        logic [31:0] maddr;
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_vec_t;

    rd_vec_t rv [5];

    initial begin
        int n;
        logic [31:0] c0;
        logic [31:0] hold_data;

        rv[0] = '{1'b1, 32'h0000_0040, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 2'b00};
        rv[1] = '{1'b0, 32'h0000_0047, 1'b0, 32'h0000_0044, 32'h1234_5678, 2'b00};
        rv[2] = '{1'b1, 32'h0000_0080, 1'b1, 32'h0000_0080, 32'hA5A5_0F0F, 2'b10};
        rv[3] = '{1'b0, 32'h0000_0084, 1'b0, 32'h0000_0084, 32'h0BAD_F00D, 2'b00};
        rv[4] = '{1'b1, 32'h0000_0FFC, 1'b0, 32'h0000_0FFC, 32'h7654_3210, 2'b00};
        for (int i = 0; i < 1024; i++) sram[i] = 32'h0000_0000;
        for (int i = 0; i < 5; i++) sram[rv[i].maddr[11:2]] = rv[i].data;
        sram[18] = 32'h55AA_55AA;   // byte address 0x48

        ARESETn = 1'b0;
        AWID = 1'b0; AWADDR = 32'd0; AWLEN = 8'd0; AWVALID = 1'b0;
        WID = 1'b0; WLAST = 1'b0; WUSER = 1'b0; WDATA = 32'd0; WSTRB = 4'h0; WVALID = 1'b0;
        BREADY = 1'b0;
        ARID = 1'b0; ARADDR = 32'd0; ARLEN = 8'd0; ARVALID = 1'b0;
        RREADY = 1'b0; mem_error = 1'b0; mem_stall = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        check("reset_ctrl", {20'd0, ARREADY, AWREADY, WREADY, BVALID, RVALID, mem_c_en,
                             mem_w_en, BRESP, RRESP, RLAST}, 32'd0);
        check("reset_rdata", RDATA, 32'd0);
        ARESETn = 1'b1;
        tick();
        check("idle_ready", {30'd0, ARREADY, AWREADY}, 32'd0);

        // Tie from reset: read first, then the repeated tie goes to the write.
        ARID = 1'b1; ARADDR = 32'h0000_0040; ARLEN = 8'd0; ARVALID = 1'b1;
        AWID = 1'b0; AWADDR = 32'h0000_0200; AWLEN = 8'd0; AWVALID = 1'b1;
        tick();
        check("tie1_ready", {30'd0, ARREADY, AWREADY}, 32'd2);
        tick();
        ARADDR = 32'h0000_0044;
        check("tie1_cen", {31'd0, mem_c_en}, 32'd1);
        tick();
        tick();
        check("tie1_rvalid", {31'd0, RVALID}, 32'd1);
        check("tie1_rdata", RDATA, 32'hDEAD_BEEF);
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        check("tie2_ready", {30'd0, ARREADY, AWREADY}, 32'd1);
        tick();
        AWVALID = 1'b0;
        check("tie2_wready", {31'd0, WREADY}, 32'd1);
        WDATA = 32'hCAFE_0001; WSTRB = 4'hF; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        check("tie2_wr", {mem_addr[30:0], mem_w_en}, {31'h0000_0200, 1'b1});
        tick();
        check("tie2_bvalid", {31'd0, BVALID}, 32'd1);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        check("tie3_arready", {30'd0, ARREADY, AWREADY}, 32'd2);
        tick();
        ARVALID = 1'b0;
        tick();
        tick();
        check("tie3_rdata", RDATA, 32'h1234_5678);
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;

        for (int i = 0; i < 5; i++)
            do_read1(rv[i].id, rv[i].addr, rv[i].err, rv[i].maddr, rv[i].data, rv[i].resp);

        // Four stall cycles and two cycles of RREADY backpressure.
        send_ar(1'b0, 32'h0000_0048, 8'd0);
        mem_stall = 1'b1;
        for (int s = 0; s < 4; s++) begin
            check("stall_cen", {31'd0, mem_c_en}, 32'd1);
            check("stall_addr", mem_addr, 32'h0000_0048);
            check("stall_rvalid", {31'd0, RVALID}, 32'd0);
            tick();
        end
        mem_stall = 1'b0;
        tick();
        check("stall_rvalid_n6", {31'd0, RVALID}, 32'd0);
        tick();
        check("stall_rvalid_n7", {31'd0, RVALID}, 32'd1);
        check("stall_rdata", RDATA, 32'h55AA_55AA);
        hold_data = RDATA;
        tick();
        check("bp_rvalid", {31'd0, RVALID}, 32'd1);
        check("bp_rdata", RDATA, hold_data);
        check("bp_rlast", {31'd0, RLAST}, 32'd1);
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        check("bp_done", {31'd0, RVALID}, 32'd0);

        do_write(1'b1, 32'h0000_0100, 8'd3, 4'h3, 32'h1111_0000, -1, 2'b00);
        do_write(1'b0, 32'h0000_0180, 8'd3, 4'hF, 32'h2222_0000, 1, 2'b10);
        do_write(1'b1, 32'h0000_01C0, 8'd0, 4'hC, 32'h3333_0000, -1, 2'b00);
`ifndef AXI4SLAVE_ADDR_CHECK_EN
        do_write(1'b0, 32'hFFFF_FFFC, 8'd1, 4'hF, 32'h4444_0000, -1, 2'b00);
`else
        // Out-of-window read: two DECERR beats, no SRAM access.
        c0 = cen_cnt;
        send_ar(1'b1, 32'h0000_2000, 8'd1);
        for (int b = 0; b < 2; b++) begin
            n = 0;
            while (!RVALID && n < 16) begin tick(); n++; end
            if (n == 16) timeout("decerr_rvalid");
            check("decerr_rdata", RDATA, 32'd0);
            check("decerr_rresp", {30'd0, RRESP}, 32'd3);
            check("decerr_rlast", {31'd0, RLAST}, (b == 1) ? 32'd1 : 32'd0);
            RREADY = 1'b1;
            tick();
            RREADY = 1'b0;
        end
        // Out-of-window write: both beats consumed, then DECERR.
        send_aw(1'b1, 32'h0000_3000, 8'd1);
        for (int b = 0; b < 2; b++) begin
            WDATA = 32'h9999_0000; WSTRB = 4'hF; WVALID = 1'b1;
            n = 0;
            while (!WREADY && n < 16) begin tick(); n++; end
            if (n == 16) timeout("decerr_wready");
            tick();
            WVALID = 1'b0;
        end
        n = 0;
        while (!BVALID && n < 16) begin tick(); n++; end
        if (n == 16) timeout("decerr_bvalid");
        check("decerr_bresp", {30'd0, BRESP}, 32'd3);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        check("decerr_no_cen", cen_cnt, c0);
        do_read1(1'b0, 32'h0000_0040, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 2'b00);
`endif

        // Reset in the middle of a write aborts it with no response.
        send_aw(1'b1, 32'h0000_0300, 8'd2);
        check("abort_wready_pre", {31'd0, WREADY}, 32'd1);
        ARESETn = 1'b0;
        #1;
        check("abort_wready", {31'd0, WREADY}, 32'd0);
        check("abort_rdata", RDATA, 32'd0);
        tick();
        ARESETn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("abort_quiet", {29'd0, BVALID, WREADY, mem_c_en}, 32'd0);
        end
        ARVALID = 1'b1; ARADDR = 32'h0000_0040;
        AWVALID = 1'b1; AWADDR = 32'h0000_0040;
        tick();
        check("abort_tie_read", {30'd0, ARREADY, AWREADY}, 32'd2);
        ARVALID = 1'b0;
        AWVALID = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi4slave_sram.md
# axi4slave_sram

AXI4 slave that accepts read and write transactions and executes them on a single-port SRAM-style memory, one 32-bit word per beat. It is the responder counterpart to the core's AXI4 master bridge: it sits on the interconnect slave side in front of on-chip RAM or a memory-mapped peripheral. It uses the same SRAM-style signal set, with directions reversed so that this block drives the memory. The block is a single FSM that services one transaction at a time and supports INCR-style bursts of up to 256 beats.

## Interface
- Clock: ACLK. Reset: ARESETn, asynchronous, active-low.
- Parameters:
- ADDR_BASE, 32'h0000_0000, first byte address decoded (used only with the configuration macro).
- ADDR_SIZE, 32'h0001_0000, decoded window size in bytes (used only with the configuration macro).
- Ports:
- ACLK  in  1  AXI clock.
- ARESETn  in  1  asynchronous active-low reset.
- AWID/AWADDR/AWLEN/AWVALID  in  1/32/8/1  write address; AWREADY  out  1.
- WDATA/WSTRB/WVALID  in  32/4/1  write data; WREADY  out  1.
- BID/BRESP/BVALID  out  1/2/1  write response; BREADY  in  1.
- ARID/ARADDR/ARLEN/ARVALID  in  1/32/8/1  read address; ARREADY  out  1.
- RID/RDATA/RRESP/RLAST/RVALID  out  1/32/2/1/1  read data; RREADY  in  1.
- Other AW/AR/W sideband inputs (SIZE, BURST, LOCK, CACHE, PROT, QOS, REGION, USER, WID, WLAST)  in  various  ignored.
- BUSER/RUSER  out  1  tied 0.
- mem_addr  out  32  SRAM byte address; bits [1:0] are always 0.
- mem_wdata  out  32  SRAM write data.
- mem_rdata  in  32  SRAM read data, valid the cycle after an accepted read.
- mem_c_en / mem_w_en  out  1  chip enable / write enable.
- mem_b_en  out  4  byte enables: WSTRB for writes, 4'hF for reads.
- mem_error  in  1  SRAM error indicator.
- mem_stall  in  1  SRAM stall; when high, the current request is held unchanged.

## Operation
- States: IDLE, WR_DATA, WR_MEM, WR_RESP, RD_MEM, RD_WAIT, RD_DATA.
- IDLE:
  - ARREADY and AWREADY are driven by arbitration.
  - If only one of ARVALID or AWVALID is high, that channel is granted.
  - If both are high, the channel not granted last time wins. The last-grant flag resets to "write", so a read wins the first tie.
  - On a handshake the block captures ID, address (with [1:0] cleared) and the beat counter = LEN.
- WR_DATA: WREADY=1. On the W handshake, capture WDATA and WSTRB, then go to WR_MEM.
- WR_MEM:
  - Drive c_en=1, w_en=1, b_en=WSTRB.
  - If mem_stall=1, stay in WR_MEM.
  - Otherwise the write is accepted. OR mem_error into a sticky error flag.
  - If the counter is 0, go to WR_RESP. Else decrement the counter, add 4 to the address, and go to WR_DATA.
- WR_RESP: BVALID=1 with BRESP = sticky error ? 2'b10 : 2'b00. On BREADY, go to IDLE and clear the error flag.
- RD_MEM: drive c_en=1, w_en=0, b_en=4'hF. If mem_stall=1, hold; otherwise go to RD_WAIT.
- RD_WAIT: register mem_rdata into RDATA and mem_error into RRESP (error ? 2'b10 : 2'b00), then go to RD_DATA.
- RD_DATA:
  - RVALID=1; RLAST = (counter==0).
  - On the RREADY handshake: if last, go to IDLE; else decrement the counter, add 4 to the address, and go to RD_MEM.
- WLAST is ignored; the beat count comes only from AWLEN.
- Address increment wraps modulo 2^32. Burst type is ignored and always treated as INCR.
- Outputs are registered or decoded from state. No combinational path runs from AXI inputs to AXI outputs.

## Timing
- Reset values: every valid/ready output, mem_c_en, mem_w_en, BRESP, RRESP, RLAST and RDATA are 0; the FSM is in IDLE.
- Reset asserted mid-transaction aborts it immediately. No response is issued.
- Read latency, AR handshake at edge N:
  - mem_c_en is high in cycle N+1.
  - RVALID is high in cycle N+3 when mem_stall=0.
  - Each cycle of stall adds one cycle.
- Write latency, AW handshake at edge N and W handshake at edge N+1: mem write happens in cycle N+2, BVALID is high in cycle N+3.
- Burst throughput: 3 cycles per read beat, 2 cycles per write beat, plus stalls and backpressure.
- RDATA, RRESP, RLAST, BRESP and the ID outputs stay stable while their VALID is high and READY is low.

## Configuration
- AXI4SLAVE_ADDR_CHECK_EN defined:
  - An AW/AR address outside [ADDR_BASE, ADDR_BASE+ADDR_SIZE) is still accepted, but no SRAM access is made (mem_c_en stays 0).
  - For writes, all W beats are consumed, then BRESP=2'b11 (DECERR) is returned.
  - For reads, LEN+1 beats are returned with RDATA=0 and RRESP=2'b11.
  - Only the start address is checked.
- Not defined: all addresses are forwarded, and the parameters are unused.

## Test plan
- Single read: ARADDR=0x40, ARID=1, mem_rdata=0xDEADBEEF -> RVALID in cycle N+3, RDATA=0xDEADBEEF, RID=1, RRESP=0, RLAST=1.
- Write burst: AWLEN=3, AWADDR=0x100, WSTRB=4'h3 -> SRAM writes at 0x100/104/108/10C with b_en=3, then one BVALID with BRESP=0.
- Stall plus backpressure: mem_stall high for 4 cycles and RREADY low for 2 cycles -> c_en and address held, RVALID and RDATA held stable, and RVALID appears 4 cycles later than in the unstalled case.
- Error: mem_error=1 on beat 2 of a 4-beat write -> BRESP=2'b10; mem_error=1 on a read -> RRESP=2'b10 on that beat only.
- Simultaneous ARVALID and AWVALID from reset -> read served first; a repeated tie then serves the write.
- With AXI4SLAVE_ADDR_CHECK_EN, ADDR_SIZE=0x1000 and ARADDR=0x2000, ARLEN=1 -> no mem_c_en, two beats with RRESP=2'b11 and RLAST on the second.
